// File: rtl/gemm_output_deskew.sv
// Output deskew for a systolic GEMM array. Lane j arrives j cycles after
// lane 0; each lane is delayed so that all lanes of a row line up, and the
// aligned row is pushed into a small FIFO drained through a valid/ready port.
// A three-state FSM (IDLE, COLLECT, DRAIN) counts rows for one tile and
// pulses done_o once the tile has been fully drained.
//
// Output handshake: a row transfers on a rising edge where out_valid_o and
// out_ready_i are both high. out_valid_o is a function of registered FIFO
// occupancy only, and out_data_o holds while out_valid_o is high and
// out_ready_i is low.
module gemm_output_deskew #(
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic [15:0]                        num_rows_i,
  input  logic [NUM_COLS-1:0]                valid_i,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]     data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_COLS*DATA_WIDTH-1:0]     out_data_o,
  output logic                               done_o,
  output logic                               overflow_o,
  output logic                               skew_err_o,
  input  logic                               err_clr_i,
  output logic [1:0]                         fsm_state,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = NUM_COLS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_next;

  // Delayed (aligned) per-lane valid and data.
  logic [NUM_COLS-1:0] dly_v;
  logic [RW-1:0]       dly_d;

  for (genvar j = 0; j < NUM_COLS; j++) begin : g_lane
    localparam int D = NUM_COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign dly_v[j]                          = valid_i[j];
      assign dly_d[j*DATA_WIDTH +: DATA_WIDTH] = data_i[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [D-1:0]          v_sr;
      logic [DATA_WIDTH-1:0] d_sr [D];
      // Free-running shift register: D stages, no enable, cleared by reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_sr <= '0;
          for (int k = 0; k < D; k++) d_sr[k] <= '0;
        end else begin
          v_sr[0] <= valid_i[j];
          d_sr[0] <= data_i[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < D; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end
      assign dly_v[j]                          = v_sr[D-1];
      assign dly_d[j*DATA_WIDTH +: DATA_WIDTH] = d_sr[D-1];
    end
  end

  // Row detection is keyed on lane 0; any partial set of valids is a skew error.
  logic row_v;
  logic lane_mismatch;
  assign row_v         = dly_v[0];
  assign lane_mismatch = (dly_v != '0) && (dly_v != '1);

  // FIFO state.
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          in_collect, push, full, pop, wr_en, drop;

  assign in_collect = (state == COLLECT);
  assign push       = row_v && in_collect;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = out_valid_o && out_ready_i;
  assign wr_en      = push && (!full || pop);
  assign drop       = push && full && !pop;

  assign out_valid_o = (count != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

  // Row storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dly_d;
  end

  // Pointers wrap naturally at the power-of-two depth; count tells full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  // Tile bookkeeping.
  logic [15:0] rows_lat, row_cnt, row_cnt_inc;
  assign row_cnt_inc = row_cnt + 16'd1;

  // Latch the tile size on start; count every aligned row seen in COLLECT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_lat <= '0;
      row_cnt  <= '0;
    end else if (state == IDLE && start_i) begin
      rows_lat <= num_rows_i;
      row_cnt  <= '0;
    end else if (in_collect && row_v) begin
      row_cnt <= row_cnt_inc;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) state_next = (num_rows_i == 16'd0) ? DRAIN : COLLECT;
      end
      COLLECT: begin
        if (row_v && (row_cnt_inc == rows_lat)) state_next = DRAIN;
      end
      DRAIN: begin
        if (count == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // done_o is a registered one-cycle pulse marking the DRAIN -> IDLE exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_o <= 1'b0;
    else       done_o <= (state == DRAIN) && (count == '0);
  end

  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_o <= 1'b0;
      skew_err_o <= 1'b0;
    end else if (err_clr_i) begin
      overflow_o <= 1'b0;
      skew_err_o <= 1'b0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      if (lane_mismatch || (row_v && !in_collect)) skew_err_o <= 1'b1;
    end
  end

  assign fsm_state  = state;
  assign fifo_count = count;

endmodule

// File: tb/tb_gemm_output_deskew.sv
// Directed bench for gemm_output_deskew with NUM_COLS=4, DATA_WIDTH=8,
// FIFO_DEPTH=4. Rows are scheduled by their lane-0 cycle; the driver skews
// each lane automatically. Expected values are hand-computed per step.
module tb_gemm_output_deskew;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [15:0] num_rows_i;
  logic [3:0]  valid_i;
  logic [31:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        done_o;
  logic        overflow_o;
  logic        skew_err_o;
  logic        err_clr_i;
  logic [1:0]  fsm_state;
  logic [2:0]  fifo_count;

  int vectors     = 0;
  int miscompares = 0;

  int         sched [0:31];
  logic [7:0] base  [0:7];
  int         late_lane;
  int         done_cnt;
  int         emitted;

  gemm_output_deskew #(.NUM_COLS(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .num_rows_i  (num_rows_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .skew_err_o  (skew_err_o),
    .err_clr_i   (err_clr_i),
    .fsm_state   (fsm_state),
    .fifo_count  (fifo_count)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 32; i++) sched[i] = -1;
    late_lane = -1;
  endtask

  // Drive lane j with the row whose lane-0 cycle was t-j (one more for the late lane).
  task automatic drive_sched(input int t);
    logic [3:0]  v;
    logic [31:0] d;
    v = '0;
    d = '0;
    for (int j = 0; j < 4; j++) begin
      int s;
      s = t - j - ((j == late_lane) ? 1 : 0);
      if (s >= 0 && s < 32) begin
        if (sched[s] >= 0) begin
          v[j] = 1'b1;
          d[j*8 +: 8] = base[sched[s]] + 8'(j);
        end
      end
    end
    valid_i = v;
    data_i  = d;
  endtask

  // Issue start in the current cycle; returns in the first cycle of the tile.
  task automatic start_tile(input logic [15:0] rows, input logic ready);
    start_i     = 1'b1;
    num_rows_i  = rows;
    out_ready_i = ready;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start_i     = 1'b0;
    num_rows_i  = '0;
    valid_i     = '0;
    data_i      = '0;
    out_ready_i = 1'b0;
    err_clr_i   = 1'b0;
    clear_sched();
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data",  64'(out_data_o),  64'd0);
    check("rst_done",      64'(done_o),      64'd0);
    check("rst_flags",     64'({overflow_o, skew_err_o}), 64'd0);
    check("rst_state",     64'(fsm_state),   64'(S_IDLE));
    tick();
    tick();
    reset = 1'b0;

    // Two skewed rows, consumer always ready.
    start_tile(16'd2, 1'b1);
    check("t1_start", 64'(fsm_state), 64'(S_COLLECT));
    clear_sched();
    sched[0] = 0; base[0] = 8'h10;
    sched[1] = 1; base[1] = 8'h20;
    done_cnt = 0;
    for (int t = 0; t <= 10; t++) begin
      drive_sched(t);
      if (done_o) done_cnt++;
      if (t == 3) check("t1_valid_c3", 64'(out_valid_o), 64'd0);
      if (t == 4) begin
        check("t1_valid_c4", 64'(out_valid_o), 64'd1);
        check("t1_row0",     64'(out_data_o),  64'h13121110);
      end
      if (t == 5) begin
        check("t1_valid_c5", 64'(out_valid_o), 64'd1);
        check("t1_row1",     64'(out_data_o),  64'h23222120);
      end
      if (t == 6) check("t1_valid_c6", 64'(out_valid_o), 64'd0);
      if (t == 7) begin
        check("t1_done_c7", 64'(done_o),    64'd1);
        check("t1_idle_c7", 64'(fsm_state), 64'(S_IDLE));
      end
      tick();
    end
    check("t1_done_once", 64'(done_cnt), 64'd1);
    check("t1_flags",     64'({overflow_o, skew_err_o}), 64'd0);

    // Six back-to-back rows into a stalled consumer: four held, two dropped.
    start_tile(16'd6, 1'b0);
    clear_sched();
    for (int i = 0; i < 6; i++) begin
      sched[i] = i;
      base[i]  = 8'h30 + 8'(i * 16);
    end
    done_cnt = 0;
    for (int t = 0; t <= 19; t++) begin
      drive_sched(t);
      out_ready_i = (t >= 12);
      if (done_o) done_cnt++;
      if (t == 7)  check("t2_no_ovf_c7", 64'(overflow_o), 64'd0);
      if (t == 8)  check("t2_hold_c8",   64'(out_data_o), 64'h33323130);
      if (t == 10) begin
        check("t2_count", 64'(fifo_count), 64'd4);
        check("t2_ovf",   64'(overflow_o), 64'd1);
        check("t2_state", 64'(fsm_state),  64'(S_DRAIN));
      end
      if (t == 11) check("t2_no_done", 64'(done_cnt), 64'd0);
      if (t == 12) check("t2_row0", 64'(out_data_o), 64'h33323130);
      if (t == 13) check("t2_row1", 64'(out_data_o), 64'h43424140);
      if (t == 14) check("t2_row2", 64'(out_data_o), 64'h53525150);
      if (t == 15) check("t2_row3", 64'(out_data_o), 64'h63626160);
      if (t == 16) check("t2_empty", 64'(out_valid_o), 64'd0);
      if (t == 17) check("t2_done_c17", 64'(done_o), 64'd1);
      tick();
    end
    check("t2_done_once", 64'(done_cnt), 64'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t2_ovf_cleared", 64'(overflow_o), 64'd0);

    // Full FIFO with a pop in the same cycle a new row lands.
    start_tile(16'd5, 1'b0);
    clear_sched();
    for (int i = 0; i < 5; i++) begin
      sched[i] = i;
      base[i]  = 8'hA0 + 8'(i * 16);
    end
    for (int t = 0; t <= 17; t++) begin
      drive_sched(t);
      out_ready_i = (t == 7) || (t >= 10);
      if (t == 7) begin
        check("t3_full_c7", 64'(fifo_count), 64'd4);
        check("t3_head_c7", 64'(out_data_o), 64'hA3A2A1A0);
      end
      if (t == 8) begin
        check("t3_count_c8", 64'(fifo_count), 64'd4);
        check("t3_no_ovf",   64'(overflow_o), 64'd0);
        check("t3_head_c8",  64'(out_data_o), 64'hB3B2B1B0);
      end
      if (t == 13) check("t3_row4", 64'(out_data_o), 64'hE3E2E1E0);
      if (t == 15) check("t3_done", 64'(done_o), 64'd1);
      tick();
    end

    // Lane 2 one cycle late: skew error, row still pushed and counted.
    start_tile(16'd1, 1'b1);
    clear_sched();
    sched[0] = 0; base[0] = 8'hF0;
    late_lane = 2;
    done_cnt = 0;
    for (int t = 0; t <= 8; t++) begin
      drive_sched(t);
      err_clr_i = (t == 5);
      if (done_o) done_cnt++;
      if (t == 3) check("t4_skew_c3", 64'(skew_err_o), 64'd0);
      if (t == 4) begin
        check("t4_skew_c4", 64'(skew_err_o),  64'd1);
        check("t4_valid",   64'(out_valid_o), 64'd1);
        check("t4_row",     64'(out_data_o),  64'hF300F1F0);
        check("t4_counted", 64'(fsm_state),   64'(S_DRAIN));
      end
      if (t == 5) check("t4_skew_c5", 64'(skew_err_o), 64'd1);
      if (t == 6) check("t4_skew_clr", 64'(skew_err_o), 64'd0);
      tick();
    end
    err_clr_i = 1'b0;
    check("t4_done_once", 64'(done_cnt), 64'd1);

    // Reset mid-tile with a row buffered and the next wavefront half in flight.
    start_tile(16'd2, 1'b0);
    clear_sched();
    sched[0] = 0; base[0] = 8'h60;
    sched[3] = 1; base[1] = 8'h70;
    for (int t = 0; t <= 4; t++) begin
      drive_sched(t);
      if (t == 4) begin
        check("t5_pre_valid", 64'(out_valid_o), 64'd1);
        check("t5_pre_data",  64'(out_data_o),  64'h63626160);
      end
      if (t < 4) tick();
    end
    #2;
    reset   = 1'b1;
    valid_i = '0;
    data_i  = '0;
    #1;
    check("t5_rst_valid", 64'(out_valid_o), 64'd0);
    check("t5_rst_data",  64'(out_data_o),  64'd0);
    check("t5_rst_state", 64'(fsm_state),   64'(S_IDLE));
    check("t5_rst_count", 64'(fifo_count),  64'd0);
    tick();
    tick();
    reset = 1'b0;
    start_tile(16'd1, 1'b1);
    check("t5_start_first_edge", 64'(fsm_state), 64'(S_COLLECT));
    clear_sched();
    emitted = 0;
    for (int t = 0; t <= 7; t++) begin
      drive_sched(t);
      if (out_valid_o) emitted++;
      tick();
    end
    check("t5_no_ghost_row", 64'(emitted), 64'd0);
    check("t5_no_skew",      64'(skew_err_o), 64'd0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();

    // Zero-row tile, then a row arriving while idle.
    start_tile(16'd0, 1'b1);
    check("t6_done_c1",  64'(done_o),    64'd0);
    check("t6_drain",    64'(fsm_state), 64'(S_DRAIN));
    tick();
    check("t6_done_c2",  64'(done_o),    64'd1);
    check("t6_idle",     64'(fsm_state), 64'(S_IDLE));
    tick();
    check("t6_done_c3",  64'(done_o),    64'd0);
    clear_sched();
    sched[0] = 0; base[0] = 8'h40;
    emitted = 0;
    for (int t = 0; t <= 6; t++) begin
      drive_sched(t);
      if (out_valid_o) emitted++;
      if (t == 3) check("t6_skew_c3", 64'(skew_err_o), 64'd0);
      if (t == 4) check("t6_skew_c4", 64'(skew_err_o), 64'd1);
      tick();
    end
    check("t6_discarded", 64'(emitted),    64'd0);
    check("t6_count",     64'(fifo_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
